mem_access_phase: RTL and testbench
===================================

MEM_ACCESS_PHASE -- requirements
Module: mem_access_phase

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, data-memory read latency in cycles from mem_en to valid mem_rdata (legal 1..7).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  one-cycle request pulse from execute stage.
REQ-005 SHALL have port opcode  input  `OPCODE_W  instruction opcode, sampled with start.
REQ-006 SHALL have port addr  input  `ADDR_W  word address, sampled with start.
REQ-007 SHALL have port st_data  input  `REG_W  store data, sampled with start.
REQ-008 SHALL have port busy  output  1  high while a request is in progress.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port ld_data  output  `REG_W  load/input result for write-back.
REQ-011 SHALL have ports mem_en, mem_we  output  1 each  data-memory enable and write enable.
REQ-012 SHALL have ports mem_addr  output  `ADDR_W, mem_wdata  output  `REG_W  data-memory address and write data.
REQ-013 SHALL have port mem_rdata  input  `REG_W  data-memory read data.
REQ-014 SHALL have ports rx_data  input  8, rx_valid  input  1, rx_ready  output  1  byte stream from the UART receiver.

Function
REQ-015 SHALL implement FSM states IDLE, MEM_REQ, MEM_WAIT, RX, DONE.
REQ-016 In IDLE, start=1 SHALL latch opcode/addr/st_data and go to MEM_REQ for LW, LWCZ, SW, SWCZ, to RX for ININT, INFLT, and to DONE for any other opcode.
REQ-017 start while busy=1 SHALL be ignored; busy SHALL be high in every state except IDLE.
REQ-018 MEM_REQ SHALL last one cycle with mem_en=1 and mem_addr=latched addr; mem_we=1 and mem_wdata=st_data for SW/SWCZ only.
REQ-019 After MEM_REQ, stores SHALL go to DONE; loads SHALL go to MEM_WAIT for MEM_LAT-1 cycles (zero if MEM_LAT=1), then capture mem_rdata into ld_data and go to DONE.
REQ-020 Load latency SHALL be MEM_LAT+1 cycles from start to done; store latency SHALL be 2 cycles; other opcodes SHALL take 1 cycle.
REQ-021 mem_en and mem_we SHALL be 0 outside MEM_REQ.
REQ-022 In RX, rx_ready SHALL be 1; each cycle with rx_valid&rx_ready SHALL accept one byte and advance a 2-bit byte counter.
REQ-023 The 4th accepted byte SHALL complete the word: ld_data is updated and the FSM goes to DONE. rx_ready SHALL be 0 in all other states.
REQ-024 rx_valid=0 in RX SHALL stall indefinitely with no timeout; partial bytes SHALL be kept.
REQ-025 DONE SHALL last one cycle with done=1 and then return to IDLE. A start in the DONE cycle SHALL be ignored.
REQ-026 ld_data SHALL change only on load capture or 4th-byte completion. It SHALL hold its value otherwise, including across stores and other opcodes.

Reset
REQ-027 rst=1 SHALL asynchronously force IDLE, byte counter 0, and all outputs 0 (busy, done, ld_data, mem_en, mem_we, mem_addr, mem_wdata, rx_ready).
REQ-028 rst mid-operation SHALL abandon the request without producing done. An in-flight mem_rdata SHALL be discarded, and a partially assembled RX word SHALL be discarded.

Configuration
REQ-029 With IN_BIG_ENDIAN_EN defined, the first received byte SHALL land in ld_data[31:24] and the 4th in [7:0].
REQ-030 With IN_BIG_ENDIAN_EN undefined, the first received byte SHALL land in ld_data[7:0] and the 4th in [31:24].

Verification
REQ-031 MEM_LAT=2, start LW addr=0x10, memory holds 0xDEADBEEF -> mem_en=1, mem_addr=0x10 in cycle 1; done=1 and ld_data=0xDEADBEEF in cycle 3.
REQ-032 start SW addr=0x20, st_data=0x12345678 -> cycle 1 has mem_en=mem_we=1, mem_addr=0x20, mem_wdata=0x12345678; done in cycle 2; ld_data unchanged.
REQ-033 start ININT, bytes 0x01,0x02,0x03,0x04 with rx_valid gaps of 3 cycles -> done one cycle after the 4th byte. ld_data=0x01020304 with IN_BIG_ENDIAN_EN, 0x04030201 without it.
REQ-034 second start pulse during a LW in progress -> ignored; exactly one done; memory accessed once.
REQ-035 rst asserted after 2 of 4 RX bytes, then ININT again with 0xAA,0xBB,0xCC,0xDD -> no done before reset. Result (big-endian) SHALL be 0xAABBCCDD with no stale bytes.
REQ-036 start with a non-memory opcode (e.g. ADD) -> done in cycle 1, mem_en never asserted, rx_ready never asserted.

Source files
------------

// File: rtl/mem_access_phase.sv
// -----------------------------------------------------------------------------
// mem_access_phase
//
// Memory/input phase of the pipeline. Accepts one request per start pulse from
// the execute stage and runs it to completion:
//   - loads  (LW, LWCZ)   : one data-memory read, result captured into ld_data
//   - stores (SW, SWCZ)   : one data-memory write, ld_data untouched
//   - inputs (ININT,INFLT): assemble a 32-bit word from four UART bytes
//   - anything else       : no side effects, completes in one cycle
//
// Build option:
//   IN_BIG_ENDIAN_EN  defined   -> first received byte lands in ld_data[31:24]
//                     undefined -> first received byte lands in ld_data[7:0]
//
// Parameter:
//   MEM_LAT   data-memory read latency (1..7). mem_rdata is sampled on the
//             MEM_LAT-th rising edge after the edge that raised mem_en, so a
//             load completes MEM_LAT+1 cycles after start.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               one-cycle request pulse (ignored while busy)
//   opcode/addr/st_data request fields, sampled with start
//   busy                high in every state but IDLE
//   done                one-cycle completion pulse
//   ld_data             load / input result for write-back
//   mem_en/mem_we       data-memory enable / write enable (MEM_REQ cycle only)
//   mem_addr/mem_wdata  data-memory address / write data
//   mem_rdata           data-memory read data
//   rx_data/rx_valid    byte stream from the UART receiver
//   rx_ready            high while waiting for input bytes
//
// Opcode encoding (OPCODE_W = 6):
//   ADD 0x00, LW 0x10, LWCZ 0x11, SW 0x12, SWCZ 0x13, ININT 0x20, INFLT 0x21
// The byte assembly assumes REG_W = 32.
// -----------------------------------------------------------------------------
`ifndef OPCODE_W
`define OPCODE_W 6
`endif
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef REG_W
`define REG_W 32
`endif

module mem_access_phase #(
  parameter int MEM_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [`OPCODE_W-1:0] opcode,
  input  logic [`ADDR_W-1:0]   addr,
  input  logic [`REG_W-1:0]    st_data,
  output logic                 busy,
  output logic                 done,
  output logic [`REG_W-1:0]    ld_data,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [`ADDR_W-1:0]   mem_addr,
  output logic [`REG_W-1:0]    mem_wdata,
  input  logic [`REG_W-1:0]    mem_rdata,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready
);

  localparam logic [`OPCODE_W-1:0] OP_LW    = `OPCODE_W'('h10);
  localparam logic [`OPCODE_W-1:0] OP_LWCZ  = `OPCODE_W'('h11);
  localparam logic [`OPCODE_W-1:0] OP_SW    = `OPCODE_W'('h12);
  localparam logic [`OPCODE_W-1:0] OP_SWCZ  = `OPCODE_W'('h13);
  localparam logic [`OPCODE_W-1:0] OP_ININT = `OPCODE_W'('h20);
  localparam logic [`OPCODE_W-1:0] OP_INFLT = `OPCODE_W'('h21);

  // MEM_WAIT lasts MEM_LAT-1 cycles; the counter holds the cycles left after
  // the current one, so it starts at MEM_LAT-2.
  localparam logic [2:0] WAIT_INIT = 3'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_RX,
    S_DONE
  } state_t;

  state_t      r_state;
  logic        r_is_store;
  logic [2:0]  r_wait_cnt;
  logic [1:0]  r_byte_cnt;
  logic [23:0] r_rx_buf;    // first three received bytes

  logic w_is_load;
  logic w_is_store;
  logic w_is_rx;
  logic [23:0] w_rx_buf_nxt;
  logic [31:0] w_rx_word;

  assign w_is_load  = (opcode == OP_LW)    || (opcode == OP_LWCZ);
  assign w_is_store = (opcode == OP_SW)    || (opcode == OP_SWCZ);
  assign w_is_rx    = (opcode == OP_ININT) || (opcode == OP_INFLT);

  // Partial bytes are shifted in so that after three bytes the buffer already
  // sits in its final position; the 4th byte is concatenated on the open end.
`ifdef IN_BIG_ENDIAN_EN
  assign w_rx_buf_nxt = {r_rx_buf[15:0], rx_data};
  assign w_rx_word    = {r_rx_buf, rx_data};
`else
  assign w_rx_buf_nxt = {rx_data, r_rx_buf[23:8]};
  assign w_rx_word    = {rx_data, r_rx_buf};
`endif

  // Single FSM; every output is a register loaded alongside the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_is_store <= 1'b0;
      r_wait_cnt <= 3'd0;
      r_byte_cnt <= 2'd0;
      r_rx_buf   <= 24'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ld_data    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rx_ready   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (w_is_load || w_is_store) begin
              r_state    <= S_MEM_REQ;
              r_is_store <= w_is_store;
              mem_en     <= 1'b1;
              mem_we     <= w_is_store;
              mem_addr   <= addr;
              mem_wdata  <= w_is_store ? st_data : '0;
            end else if (w_is_rx) begin
              r_state    <= S_RX;
              r_byte_cnt <= 2'd0;
              r_rx_buf   <= 24'd0;
              rx_ready   <= 1'b1;
            end else begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end
          end
        end

        S_MEM_REQ: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (r_is_store) begin
            r_state <= S_DONE;
            done    <= 1'b1;
          end else if (MEM_LAT == 1) begin
            // Single-cycle memory: data is already valid at this edge.
            ld_data <= mem_rdata;
            r_state <= S_DONE;
            done    <= 1'b1;
          end else begin
            r_wait_cnt <= WAIT_INIT;
            r_state    <= S_MEM_WAIT;
          end
        end

        S_MEM_WAIT: begin
          if (r_wait_cnt == 3'd0) begin
            ld_data <= mem_rdata;
            r_state <= S_DONE;
            done    <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt - 3'd1;
          end
        end

        S_RX: begin
          // rx_ready is high throughout this state, so rx_valid alone is
          // the handshake. No timeout: the FSM waits here indefinitely.
          if (rx_valid) begin
            if (r_byte_cnt == 2'd3) begin
              ld_data    <= `REG_W'(w_rx_word);
              r_byte_cnt <= 2'd0;
              r_rx_buf   <= 24'd0;
              rx_ready   <= 1'b0;
              r_state    <= S_DONE;
              done       <= 1'b1;
            end else begin
              r_rx_buf   <= w_rx_buf_nxt;
              r_byte_cnt <= r_byte_cnt + 2'd1;
            end
          end
        end

        S_DONE: begin
          // start is not looked at here, so a pulse in this cycle is dropped.
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state  <= S_IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          mem_en   <= 1'b0;
          mem_we   <= 1'b0;
          rx_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_phase.sv
// -----------------------------------------------------------------------------
// tb_mem_access_phase
//
// Randomized self-checking bench. The reference model works per request: from
// the opcode class it computes the completion cycle, which cycles drive the
// memory / UART handshakes, and the resulting ld_data, then compares the DUT
// every cycle of the request. Memory contents are mirrored in ref_mem, which
// is updated from the store rule rather than from DUT outputs.
// -----------------------------------------------------------------------------
`ifndef OPCODE_W
`define OPCODE_W 6
`endif
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef REG_W
`define REG_W 32
`endif

module tb_mem_access_phase;

  localparam int MEM_LAT = 2;

  localparam logic [`OPCODE_W-1:0] OP_ADD   = `OPCODE_W'('h00);
  localparam logic [`OPCODE_W-1:0] OP_LW    = `OPCODE_W'('h10);
  localparam logic [`OPCODE_W-1:0] OP_LWCZ  = `OPCODE_W'('h11);
  localparam logic [`OPCODE_W-1:0] OP_SW    = `OPCODE_W'('h12);
  localparam logic [`OPCODE_W-1:0] OP_SWCZ  = `OPCODE_W'('h13);
  localparam logic [`OPCODE_W-1:0] OP_ININT = `OPCODE_W'('h20);
  localparam logic [`OPCODE_W-1:0] OP_INFLT = `OPCODE_W'('h21);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [`OPCODE_W-1:0] opcode;
  logic [`ADDR_W-1:0]   addr;
  logic [`REG_W-1:0]    st_data;
  logic                 busy;
  logic                 done;
  logic [`REG_W-1:0]    ld_data;
  logic                 mem_en;
  logic                 mem_we;
  logic [`ADDR_W-1:0]   mem_addr;
  logic [`REG_W-1:0]    mem_wdata;
  logic [`REG_W-1:0]    mem_rdata;
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  mem_access_phase #(.MEM_LAT(MEM_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .opcode    (opcode),
    .addr      (addr),
    .st_data   (st_data),
    .busy      (busy),
    .done      (done),
    .ld_data   (ld_data),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory model: 256 words, read data valid only in the cycle the DUT is
  // supposed to sample it; random garbage at all other times.
  logic [31:0] ram     [0:255];
  logic [31:0] ref_mem [0:255];
  int          mem_acc = 0;
  bit          pend = 0;
  int          pcyc = 0;
  logic [7:0]  paddr = 8'd0;

  always @(negedge clk) begin
    if (mem_en === 1'b1) begin
      mem_acc++;
      pend  = 1'b1;
      pcyc  = cyc;
      paddr = mem_addr[7:0];
      if (mem_we === 1'b1) ram[mem_addr[7:0]] = mem_wdata;
    end
    if (pend && cyc == pcyc + MEM_LAT - 1) mem_rdata = ram[paddr];
    else mem_rdata = $urandom;
  end

  logic [31:0] exp_ld = 32'd0;

  // Run one request. rxw holds the four input bytes, first byte in [31:24].
  // gap = idle cycles before each byte. xstart adds a second start pulse in
  // cycle 1, when the DUT must be busy (MEM_REQ, RX or DONE).
  task automatic do_op(input logic [`OPCODE_W-1:0] op, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] rxw,
                       input int gap, input bit xstart);
    bit          is_ld, is_st, is_rx;
    int          done_at, bi, gcnt, acc0;
    logic [31:0] old_ld, new_ld;
    is_ld  = (op == OP_LW) || (op == OP_LWCZ);
    is_st  = (op == OP_SW) || (op == OP_SWCZ);
    is_rx  = (op == OP_ININT) || (op == OP_INFLT);
    old_ld = exp_ld;
    new_ld = exp_ld;
    if (is_ld) begin
      done_at = MEM_LAT + 1;
      new_ld  = ref_mem[a[7:0]];
    end else if (is_st) begin
      done_at = 2;
      ref_mem[a[7:0]] = sd;
    end else if (is_rx) begin
      done_at = 1000;  // fixed once the 4th byte is driven
`ifdef IN_BIG_ENDIAN_EN
      new_ld = rxw;
`else
      new_ld = {rxw[7:0], rxw[15:8], rxw[23:16], rxw[31:24]};
`endif
    end else begin
      done_at = 1;
    end
    acc0 = mem_acc;

    @(negedge clk);
    start    = 1'b1;
    opcode   = op;
    addr     = a;
    st_data  = sd;
    rx_valid = 1'($urandom);
    rx_data  = 8'($urandom);
    bi   = 0;
    gcnt = gap;
    for (int n = 1; n <= done_at + 1 && n < 200; n++) begin
      @(negedge clk);
      start   = xstart && (n == 1);
      opcode  = `OPCODE_W'($urandom);
      addr    = $urandom;
      st_data = $urandom;
      chk("busy",     32'(busy),     32'(n <= done_at));
      chk("done",     32'(done),     32'(n == done_at));
      chk("mem_en",   32'(mem_en),   32'((is_ld || is_st) && n == 1));
      chk("mem_we",   32'(mem_we),   32'(is_st && n == 1));
      chk("rx_ready", 32'(rx_ready), 32'(is_rx && n < done_at));
      chk("ld_data",  ld_data,       (n >= done_at) ? new_ld : old_ld);
      if (n == 1 && (is_ld || is_st)) chk("mem_addr", mem_addr, a);
      if (n == 1 && is_st) chk("mem_wdata", mem_wdata, sd);
      if (is_rx && bi < 4) begin
        if (gcnt > 0) begin
          rx_valid = 1'b0;
          rx_data  = 8'($urandom);
          gcnt--;
        end else begin
          rx_valid = 1'b1;
          rx_data  = rxw[31-8*bi -: 8];
          bi++;
          gcnt = gap;
          if (bi == 4) done_at = n + 1;
        end
      end else begin
        rx_valid = 1'($urandom);
        rx_data  = 8'($urandom);
      end
    end
    if (done_at >= 200) chk("rx_timeout", 32'(bi), 32'd4);
    chk("mem_acc", 32'(mem_acc - acc0), 32'((is_ld || is_st) ? 1 : 0));
    exp_ld = new_ld;
    start  = 1'b0;
  endtask

  initial begin
    logic [`OPCODE_W-1:0] rop;
    int sel;
    for (int i = 0; i < 256; i++) begin
      ram[i]     = $urandom;
      ref_mem[i] = ram[i];
    end
    ram[8'h10]     = 32'hDEADBEEF;
    ref_mem[8'h10] = 32'hDEADBEEF;

    rst = 1'b1; start = 1'b0; opcode = '0; addr = '0; st_data = '0;
    rx_valid = 1'b0; rx_data = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_ld_data",  ld_data,       32'd0);
    chk("rst_mem_en",   32'(mem_en),   32'd0);
    chk("rst_mem_we",   32'(mem_we),   32'd0);
    chk("rst_mem_addr", mem_addr,      32'd0);
    chk("rst_mem_wdat", mem_wdata,     32'd0);
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    rst = 1'b0;

    // Directed cases.
    do_op(OP_LW,    32'h10, 32'h0,        32'h0,        0, 1'b0);
    chk("lw_deadbeef", ld_data, 32'hDEADBEEF);
    do_op(OP_SW,    32'h20, 32'h12345678, 32'h0,        0, 1'b0);
    chk("sw_keeps_ld", ld_data, 32'hDEADBEEF);
    do_op(OP_ININT, 32'h0,  32'h0,        32'h01020304, 3, 1'b0);
    do_op(OP_LW,    32'h20, 32'h0,        32'h0,        0, 1'b1);
    chk("lw_readback", ld_data, 32'h12345678);
    do_op(OP_ADD,   32'h0,  32'h0,        32'h0,        0, 1'b1);

    // Reset in the middle of input assembly.
    @(negedge clk);
    start = 1'b1; opcode = OP_ININT;
    @(negedge clk);
    start = 1'b0; opcode = OP_ADD;
    rx_valid = 1'b1; rx_data = 8'h11;
    @(negedge clk);
    chk("rxrst_done1", 32'(done), 32'd0);
    rx_data = 8'h22;
    @(negedge clk);
    chk("rxrst_done2", 32'(done), 32'd0);
    rx_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_busy",     32'(busy),     32'd0);
    chk("arst_rx_ready", 32'(rx_ready), 32'd0);
    chk("arst_done",     32'(done),     32'd0);
    chk("arst_ld_data",  ld_data,       32'd0);
    exp_ld = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    do_op(OP_ININT, 32'h0, 32'h0, 32'hAABBCCDD, 1, 1'b0);
`ifdef IN_BIG_ENDIAN_EN
    chk("rx_after_rst", ld_data, 32'hAABBCCDD);
`else
    chk("rx_after_rst", ld_data, 32'hDDCCBBAA);
`endif

    // Randomized mix.
    for (int k = 0; k < 80; k++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0: rop = OP_LW;
        1: rop = OP_LWCZ;
        2: rop = OP_SW;
        3: rop = OP_SWCZ;
        4: rop = OP_ININT;
        5: rop = OP_INFLT;
        6: rop = OP_ADD;
        default: rop = `OPCODE_W'($urandom_range(1, 15));
      endcase
      do_op(rop, 32'($urandom_range(0, 255)), $urandom, $urandom,
            $urandom_range(0, 3), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
